// File: rtl/bid_pkg.sv
// -----------------------------------------------------------------------------
// bid_pkg
// Shared types and constants for the bidding-arbiter master initiator.
//   bid_state_e : initiator FSM states (IDLE / BID / RESP)
//   ADDR_BASE   : base of the slave window every master address is built on
//   BID_W       : width of a bid on the req bus
//   BID_MAX     : largest bid the req bus can carry
//   mk_addr()   : slave/master address builder
// -----------------------------------------------------------------------------
package bid_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BID  = 2'd1,
        RESP = 2'd2
    } bid_state_e;

    localparam logic [31:0] ADDR_BASE = 32'hFFEF_0200;
    localparam int          BID_W     = 4;
    localparam int          BID_MAX   = 15;

    // Slave index selects the 4 KB page, master id selects the byte {id,4'h0}.
    function automatic logic [31:0] mk_addr(input logic [1:0] slave,
                                            input logic [1:0] id);
        return ADDR_BASE | {18'd0, slave, 12'd0} | {26'd0, id, 4'd0};
    endfunction

endpackage

// File: rtl/bid_balance_tracker.sv
// -----------------------------------------------------------------------------
// bid_balance_tracker
// Shadow copy of this master's arbiter-side balance. Applies the same periodic
// refill and floor-at-1 deduction rules as the arbiter so the initiator never
// bids more than it can pay.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   rst_balance   : refill amount (signed 32)
//   rst_clock     : refill period in cycles; the counter runs 0..rst_clock
//   max_balance   : ceiling applied on refill (signed 32)
//   deduct_en     : charge deduct_amt this cycle
//   deduct_amt    : amount to charge (the granted bid)
//   balance       : current balance (signed 32)
// -----------------------------------------------------------------------------
module bid_balance_tracker
    import bid_pkg::*;
#(
    parameter int INIT_BALANCE = 900
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      rst_balance,
    input  logic [31:0]      rst_clock,
    input  logic [31:0]      max_balance,
    input  logic             deduct_en,
    input  logic [BID_W-1:0] deduct_amt,
    output logic [31:0]      balance
);

    logic signed [31:0] r_balance;
    logic        [31:0] r_refill_cnt;
    logic               w_refill;

    // The sum is formed one bit wider so it is compared against the ceiling
    // before it can wrap.
    function automatic logic signed [31:0] refill_sat(input logic signed [31:0] bal,
                                                      input logic signed [31:0] add,
                                                      input logic signed [31:0] ceil);
        logic signed [32:0] sum;
        logic signed [31:0] res;
        sum = 33'(bal) + 33'(add);
        if (sum > 33'(ceil))
            res = ceil;
        else
            res = 32'(sum);
        return res;
    endfunction

    // Charging never takes the balance below 1.
    function automatic logic signed [31:0] floor_deduct(input logic signed [31:0] bal,
                                                        input logic [BID_W-1:0]  amt);
        logic signed [32:0] diff;
        logic signed [31:0] res;
        diff = 33'(bal) - $signed(33'(amt));
        if (diff < 33'sd1)
            res = 32'sd1;
        else
            res = 32'(diff);
        return res;
    endfunction

    assign w_refill = (r_refill_cnt == rst_clock);

    // A deduction that coincides with a refill is dropped, as the arbiter does.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_balance    <= 32'(INIT_BALANCE);
            r_refill_cnt <= '0;
        end else if (w_refill) begin
            r_refill_cnt <= '0;
            r_balance    <= refill_sat(r_balance, $signed(rst_balance), $signed(max_balance));
        end else begin
            r_refill_cnt <= r_refill_cnt + 32'd1;
            if (deduct_en)
                r_balance <= floor_deduct(r_balance, deduct_amt);
        end
    end

    assign balance = r_balance;

endmodule

// File: rtl/bid_master.sv
// -----------------------------------------------------------------------------
// bid_master
// Master-side initiator for the four-master bidding arbiter. Takes one local
// command at a time, bids for the bus on req, escalates the bid while starved,
// aborts after MAX_WAIT ungranted cycles, and returns read data or a write
// acknowledgement on a single-cycle response strobe.
//
// Ports
//   clk, rst                   : clock, asynchronous active-high reset
//   rst_balance/rst_clock/
//   max_balance                : refill configuration mirrored from the arbiter
//   cmd_valid/cmd_ready        : command handshake (ready only in IDLE)
//   cmd_slave/cmd_rw/
//   cmd_wdata/cmd_bid          : command payload (rw: 1 = write)
//   rsp_valid/rsp_err/rsp_rdata: response strobe, abort flag, read data
//   req                        : registered bid to the arbiter (0 outside BID)
//   grant                      : arbiter grant, same cycle as req
//   addr/RW/DataToSlave        : transfer address, direction, write data
//   DataFromSlave              : read data from the slave
// -----------------------------------------------------------------------------
module bid_master
    import bid_pkg::*;
#(
    parameter int MASTER_ID    = 0,
    parameter int ESC_CYCLES   = 8,
    parameter int MAX_WAIT     = 64,
    parameter int INIT_BALANCE = 900
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      rst_balance,
    input  logic [31:0]      rst_clock,
    input  logic [31:0]      max_balance,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_slave,
    input  logic             cmd_rw,
    input  logic [31:0]      cmd_wdata,
    input  logic [BID_W-1:0] cmd_bid,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [31:0]      rsp_rdata,
    output logic [BID_W-1:0] req,
    input  logic             grant,
    output logic [31:0]      addr,
    output logic             RW,
    output logic [31:0]      DataToSlave,
    input  logic [31:0]      DataFromSlave
);

    bid_state_e       r_state;
    bid_state_e       w_next_state;

    logic [BID_W-1:0] r_req;
    logic [31:0]      r_addr;
    logic             r_rw;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_rsp_err;
    logic [31:0]      r_wait_cnt;
    logic [31:0]      r_esc_cnt;

    logic [31:0]      w_balance;
    logic             w_accept;
    logic             w_granted;
    logic [31:0]      w_wait_inc;
    logic             w_abort;
    logic             w_esc_hit;

    // max(1, min(want, balance)).
    function automatic logic [BID_W-1:0] clamp_bid(input logic [BID_W-1:0] want,
                                                   input logic signed [31:0] bal);
        logic signed [31:0] v;
        v = $signed(32'(want));
        if (bal < v)
            v = bal;
        if (v < 32'sd1)
            v = 32'sd1;
        return BID_W'(v);
    endfunction

    // One step up, saturating at min(BID_MAX, balance).
    function automatic logic [BID_W-1:0] escalate_bid(input logic [BID_W-1:0] cur,
                                                      input logic signed [31:0] bal);
        logic signed [31:0] cap;
        logic signed [31:0] nxt;
        cap = (bal < 32'(BID_MAX)) ? bal : 32'(BID_MAX);
        if (cap < 32'sd1)
            cap = 32'sd1;
        nxt = $signed(32'(cur)) + 32'sd1;
        if (nxt > cap)
            nxt = cap;
        return BID_W'(nxt);
    endfunction

    bid_balance_tracker #(
        .INIT_BALANCE (INIT_BALANCE)
    ) u_bal (
        .clk         (clk),
        .rst         (rst),
        .rst_balance (rst_balance),
        .rst_clock   (rst_clock),
        .max_balance (max_balance),
        .deduct_en   (w_granted),
        .deduct_amt  (r_req),
        .balance     (w_balance)
    );

    assign w_accept   = (r_state == IDLE) && cmd_valid;
    assign w_granted  = (r_state == BID) && grant;
    assign w_wait_inc = r_wait_cnt + 32'd1;
    // Grant has priority over the abort on the same edge.
    assign w_abort    = (r_state == BID) && !grant && (w_wait_inc == 32'(MAX_WAIT));
    assign w_esc_hit  = (r_esc_cnt == 32'(ESC_CYCLES - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (cmd_valid) w_next_state = BID;
            BID:  if (grant || w_abort) w_next_state = RESP;
            RESP: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE:    cmd_ready = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Command latch, bid escalation, wait counting and response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req      <= '0;
            r_addr     <= '0;
            r_rw       <= 1'b0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_rsp_err  <= 1'b0;
            r_wait_cnt <= '0;
            r_esc_cnt  <= '0;
        end else if (w_accept) begin
            r_addr     <= mk_addr(cmd_slave, 2'(MASTER_ID));
            r_rw       <= cmd_rw;
            r_wdata    <= cmd_wdata;
            r_req      <= clamp_bid(cmd_bid, $signed(w_balance));
            r_wait_cnt <= '0;
            r_esc_cnt  <= '0;
        end else if (r_state == BID) begin
            if (grant) begin
                r_req     <= '0;
                r_rdata   <= DataFromSlave;
                r_rsp_err <= 1'b0;
            end else begin
                r_wait_cnt <= w_wait_inc;
                if (w_abort) begin
                    r_req     <= '0;
                    r_rsp_err <= 1'b1;
                end else if (w_esc_hit) begin
                    r_esc_cnt <= '0;
                    r_req     <= escalate_bid(r_req, $signed(w_balance));
                end else begin
                    r_esc_cnt <= r_esc_cnt + 32'd1;
                end
            end
        end
    end

    assign req         = r_req;
    assign addr        = r_addr;
    assign RW          = r_rw;
    assign DataToSlave = r_wdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_rdata   = r_rdata;

endmodule

// File: tb/tb_bid_master.sv
module tb_bid_master;

    localparam int ESC  = 8;
    localparam int MAXW = 64;
    localparam int INIT = 900;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rst_balance, rst_clock, max_balance;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_slave;
    logic        cmd_rw;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_bid;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [3:0]  req;
    logic        grant;
    logic [31:0] addr;
    logic        RW;
    logic [31:0] DataToSlave, DataFromSlave;

    int     n_asrt = 0;
    int     n_fail = 0;

    // Reference model: balance as a function of elapsed cycles and grants.
    int     cfg_rc, cfg_rb, cfg_mb;
    int     m_bal;
    longint m_cyc;

    always #5 clk = ~clk;

    bid_master #(
        .MASTER_ID    (1),
        .ESC_CYCLES   (ESC),
        .MAX_WAIT     (MAXW),
        .INIT_BALANCE (INIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rst_balance   (rst_balance),
        .rst_clock     (rst_clock),
        .max_balance   (max_balance),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_slave     (cmd_slave),
        .cmd_rw        (cmd_rw),
        .cmd_wdata     (cmd_wdata),
        .cmd_bid       (cmd_bid),
        .rsp_valid     (rsp_valid),
        .rsp_err       (rsp_err),
        .rsp_rdata     (rsp_rdata),
        .req           (req),
        .grant         (grant),
        .addr          (addr),
        .RW            (RW),
        .DataToSlave   (DataToSlave),
        .DataFromSlave (DataFromSlave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the model applies the refill every (rc+1)th cycle,
    // otherwise the granted charge with a floor of 1.
    task automatic tick(input bit ded, input int amt);
        @(posedge clk);
        if ((m_cyc % (longint'(cfg_rc) + 1)) == longint'(cfg_rc)) begin
            if (longint'(m_bal) + longint'(cfg_rb) > longint'(cfg_mb))
                m_bal = cfg_mb;
            else
                m_bal = m_bal + cfg_rb;
        end else if (ded) begin
            m_bal = (m_bal - amt < 1) ? 1 : m_bal - amt;
        end
        m_cyc++;
        #1;
    endtask

    task automatic set_cfg(input int rc, input int rb, input int mb);
        cfg_rc = rc; cfg_rb = rb; cfg_mb = mb;
        rst_clock = rc; rst_balance = rb; max_balance = mb;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        grant = 1'b0;
        @(negedge clk);
        chk("rst_req",       32'(req), 0);
        chk("rst_ready",     32'(cmd_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err",   32'(rsp_err), 0);
        chk("rst_rdata",     rsp_rdata, 0);
        chk("rst_addr",      addr, 0);
        chk("rst_rw",        32'(RW), 0);
        chk("rst_wdata",     DataToSlave, 0);
        chk("rst_balance",   dut.u_bal.balance, INIT);
        rst = 1'b0;
        m_cyc = 0;
        m_bal = INIT;
    endtask

    // One full command; ga = number of ungranted BID cycles before the grant
    // (-1: never granted, so the command aborts).
    task automatic run_cmd(input logic [1:0] sl, input logic rw, input logic [31:0] wd,
                           input logic [3:0] bd, input int ga, input logic [31:0] rd,
                           output int first_req, output int last_req,
                           output logic [31:0] bid_addr);
        int eb, cap, exp;
        bit done;
        logic [31:0] exp_addr;
        eb = (int'(bd) < m_bal) ? int'(bd) : m_bal;
        if (eb < 1) eb = 1;
        exp_addr = 32'hFFEF_0200 | (32'(sl) << 12) | (32'd1 << 4);
        chk("ready_idle", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_slave = sl; cmd_rw = rw; cmd_wdata = wd; cmd_bid = bd;
        tick(0, 0);
        cmd_valid = 1'b0; cmd_slave = ~sl; cmd_rw = ~rw; cmd_wdata = ~wd; cmd_bid = ~bd;
        chk("addr", addr, exp_addr);
        chk("rw", 32'(RW), 32'(rw));
        chk("wdata", DataToSlave, wd);
        first_req = int'(req);
        bid_addr = addr;
        last_req = 0;
        done = 0;
        for (int k = 0; k < MAXW && !done; k++) begin
            cap = (m_bal < 15) ? m_bal : 15;
            exp = eb + k / ESC;
            if (exp > cap) exp = cap;
            chk("req_bid", 32'(req), exp);
            chk("ready_bid", 32'(cmd_ready), 0);
            last_req = int'(req);
            if (k == ga) begin
                grant = 1'b1;
                DataFromSlave = rd;
                tick(1, exp);
                grant = 1'b0;
                DataFromSlave = $urandom;
                chk("rsp_valid_g", 32'(rsp_valid), 1);
                chk("rsp_err_g", 32'(rsp_err), 0);
                chk("rsp_rdata", rsp_rdata, rd);
                chk("req_after_g", 32'(req), 0);
                chk("ready_resp", 32'(cmd_ready), 0);
                done = 1;
            end else begin
                DataFromSlave = $urandom;
                tick(0, 0);
                if (k == MAXW - 1) begin
                    chk("rsp_valid_a", 32'(rsp_valid), 1);
                    chk("rsp_err_a", 32'(rsp_err), 1);
                    chk("req_after_a", 32'(req), 0);
                    chk("ready_resp_a", 32'(cmd_ready), 0);
                end
            end
        end
        chk("balance", dut.u_bal.balance, m_bal);
        tick(0, 0);
        chk("rsp_valid_end", 32'(rsp_valid), 0);
        chk("ready_back", 32'(cmd_ready), 1);
    endtask

    initial begin
        int fr, lr, g;
        logic [31:0] ba;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_slave = '0; cmd_rw = 1'b0; cmd_wdata = '0; cmd_bid = '0;
        grant = 1'b0; DataFromSlave = '0;
        set_cfg(32'h7FFF_FFFF, 0, 2000);
        do_reset();

        // Granted read: slave 2, bid 5, grant one cycle after req rises.
        run_cmd(2'd2, 1'b0, 32'h0, 4'd5, 1, 32'hCAFE_F00D, fr, lr, ba);
        chk("read_addr", ba, 32'hFFEF_2210);
        chk("read_req", fr, 5);
        chk("read_balance", dut.u_bal.balance, 895);

        // Starvation: bid climbs 3..10 then the command aborts, no charge.
        do_reset();
        run_cmd(2'd0, 1'b0, 32'h0, 4'd3, -1, 32'h0, fr, lr, ba);
        chk("starve_first", fr, 3);
        chk("starve_last", lr, 10);
        chk("starve_balance", dut.u_bal.balance, 900);

        // Grant on the same cycle the abort would fire: grant wins.
        run_cmd(2'd3, 1'b0, 32'h0, 4'd3, MAXW - 1, 32'h1234_5678, fr, lr, ba);
        chk("race_balance", dut.u_bal.balance, 890);

        // Back-to-back writes.
        for (int i = 0; i < 4; i++)
            run_cmd(2'(i), 1'b1, $urandom, 4'd2, 0, 32'h0, fr, lr, ba);

        // Clamp: balance pulled to 4 by the refill ceiling, then floored to 1.
        set_cfg(2, 0, 4);
        do_reset();
        tick(0, 0); tick(0, 0); tick(0, 0);
        chk("clamp_bal4", dut.u_bal.balance, 4);
        g = ((m_cyc + 1) % 3 == 2) ? 1 : 0;
        run_cmd(2'd1, 1'b0, 32'h0, 4'd12, g, 32'hA5A5_0001, fr, lr, ba);
        chk("clamp_req", fr, 4);
        chk("clamp_floor", dut.u_bal.balance, 1);
        run_cmd(2'd1, 1'b0, 32'h0, 4'd12, 0, 32'hA5A5_0002, fr, lr, ba);
        chk("clamp_req1", fr, 1);

        // Refill/deduct collision: grant lands on the refill cycle.
        set_cfg(10, 50, 920);
        do_reset();
        run_cmd(2'd0, 1'b0, 32'h0, 4'd5, 10 - int'(m_cyc + 1), 32'h0BAD_BEEF, fr, lr, ba);
        chk("collide_balance", dut.u_bal.balance, 920);

        // Reset while bidding 7.
        set_cfg(32'h7FFF_FFFF, 0, 2000);
        do_reset();
        cmd_valid = 1'b1; cmd_slave = 2'd1; cmd_rw = 1'b0; cmd_bid = 4'd7;
        tick(0, 0);
        cmd_valid = 1'b0;
        tick(0, 0); tick(0, 0);
        chk("mid_req7", 32'(req), 7);
        #2 rst = 1'b1;
        #1;
        chk("mid_req0", 32'(req), 0);
        chk("mid_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_ready", 32'(cmd_ready), 1);
        chk("mid_balance", dut.u_bal.balance, 900);
        @(negedge clk);
        rst = 1'b0; m_cyc = 0; m_bal = INIT;
        for (int i = 0; i < 4; i++) begin
            tick(0, 0);
            chk("mid_no_rsp", 32'(rsp_valid), 0);
        end

        // Randomized commands with periodic refills.
        set_cfg(37, 20, 1000);
        do_reset();
        for (int i = 0; i < 24; i++) begin
            g = $urandom_range(0, 12);
            if ($urandom_range(0, 9) == 0) g = -1;
            run_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                    4'($urandom_range(0, 15)), g, $urandom, fr, lr, ba);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/bid_master.md
# bid_master

Master-side initiator for the four-master bidding arbiter. Accepts one local command at a time, turns it into a bid on `req`, and waits for `grant`. When granted, it completes the single-cycle transfer and returns the read data or write acknowledgement. It keeps a shadow of its arbiter-side balance so that it never bids more than it can pay, and raises its bid while it is being starved.

## Interface
Parameters
- `MASTER_ID`, 0: master slot 0–3; selects address byte `{MASTER_ID,4'h0}`.
- `ESC_CYCLES`, 8: ungranted cycles between bid escalations.
- `MAX_WAIT`, 64: ungranted cycles before the command is aborted.
- `INIT_BALANCE`, 900: balance value on reset.

Ports
- `clk` in 1: clock. One clock domain only.
- `rst` in 1: reset, asynchronous, active-high.
- `rst_balance` in 32 (int): refill amount.
- `rst_clock` in 32 (int): refill period, counted in cycles.
- `max_balance` in 32 (int): balance ceiling.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_slave` in 2: target slave 0–3.
- `cmd_rw` in 1: 1 = write, 0 = read.
- `cmd_wdata` in 32: write data.
- `cmd_bid` in 4: requested bid.
- `rsp_valid` out 1: response strobe.
- `rsp_err` out 1: 1 = aborted.
- `rsp_rdata` out 32: captured read data.
- `req` out 4: bid to the arbiter.
- `grant` in 1: from the arbiter; combinational in the same cycle as `req`.
- `addr` out 32: `32'hFFEF_0200 | cmd_slave<<12 | MASTER_ID<<4`.
- `RW` out 1: transfer direction.
- `DataToSlave` out 32: write data to the slave.
- `DataFromSlave` in 32: read data from the slave.

## Operation
- **FSM states:** IDLE, BID, RESP.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, latch slave, rw, wdata and the bid, then go to BID.
  - Effective bid = max(1, min(`cmd_bid`, balance)).
- **BID**
  - Drive `req` with the effective bid, and drive `addr`, `RW` and `DataToSlave` from registers.
  - `wait_cnt` increments on every ungranted cycle.
  - **Escalation:** every `ESC_CYCLES` ungranted cycles, effective bid +1. It saturates at min(15, balance).
  - **Grant:** at the edge where `grant`=1, capture `DataFromSlave` into `rsp_rdata` and deduct the bid from the balance. Go to RESP with `rsp_err`=0.
  - **Abort:** when `wait_cnt` reaches `MAX_WAIT`, go to RESP with `rsp_err`=1. No deduction.
  - If `grant` and the abort condition occur together, the grant wins.
- **RESP:** `rsp_valid`=1 for exactly one cycle, then IDLE. `cmd_ready`=0.
- **Balance shadow (runs in every state)**
  - `refill_cnt` runs 0..`rst_clock`.
  - On the cycle `refill_cnt`==`rst_clock`, `refill_cnt` returns to 0 and balance = min(balance + `rst_balance`, `max_balance`). A deduction on that same cycle is dropped, matching the arbiter.
  - Deductions saturate at a floor of 1. While balance==1, `req` is forced to 1.
  - Arithmetic is 32-bit signed. Compare the sum against `max_balance` before assigning, so the sum cannot wrap.

## Timing
- **Reset values:** state IDLE, `cmd_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `req`=0, `addr`=0, `RW`=0, `DataToSlave`=0, balance=`INIT_BALANCE`, `refill_cnt`=0, `wait_cnt`=0.
- **Latency:** command accept → `req` valid on the next cycle. An immediate grant → `rsp_valid` on the cycle after that, so the minimum is 2 cycles from accept to response.
- **`req`:** registered output. It is 0 in every cycle outside BID and drops to 0 in the cycle after the grant.
- **`rsp_valid`:** no back-pressure; the consumer must take it.
- **Back-to-back commands:** the next command may be accepted in the cycle after RESP.
- **Reset mid-operation:** outputs return to reset values immediately. The pending command is dropped and no response is issued.
- **Reconfiguration:** `rst_clock` changing to a value below `refill_cnt` causes a wrap through 2^32. This is a configuration error and is not guarded.

## Structure
- **Package `bid_pkg`:**
  - `bid_state_e` enum {IDLE, BID, RESP}.
  - `ADDR_BASE`=`32'hFFEF_0200`.
  - `BID_W`=4.
  - `BID_MAX`=15.
  - the `mk_addr(slave, id)` function.
- **Sub-module `bid_balance_tracker`:** holds the balance and `refill_cnt`. Inputs: `deduct_en`, `deduct_amt`. Output: `balance`. It mirrors the arbiter's refill and floor rules and is reused by the arbiter-model scoreboard.

## Test plan
- **Granted read:** `MASTER_ID`=1, read slave 2, bid 5, grant one cycle after `req` rises → `addr`=`32'hFFEF_2210`, `rsp_rdata`=`DataFromSlave`, balance 900→895.
- **Starvation:** grant held 0, bid 3, `ESC_CYCLES`=8, `MAX_WAIT`=64 → `req` 3,4,…,10 over 64 cycles, then `rsp_valid` with `rsp_err`=1, balance unchanged.
- **Clamp:** balance forced to 4, `cmd_bid`=12 → `req`=4. After the grant the balance floors at 1 and the next `req`=1.
- **Refill/deduct collision:** `rst_clock`=10, `rst_balance`=50, `max_balance`=920, grant lands on the refill cycle → balance 900→920 with no deduction.
- **Reset mid-BID:** `rst` pulse while `req`=7 → `req`=0 asynchronously, no `rsp_valid`, balance 900.
- **Back-to-back writes:** four writes → correct `RW`/`DataToSlave`/`addr` each, and `cmd_ready` low exactly during BID and RESP.
